// File: rtl/div_bcd_out.sv
// div_bcd_out: converts a binary quotient/remainder pair into packed BCD.
// Both operands run through double-dabble (add-3 then shift) in parallel,
// stepped by one shared bit counter; the result is held for the consumer
// through a valid/ready output handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The producer keeps valid and data steady until
// that edge. ready never depends combinationally on valid; it is decoded
// from the registered state only.
module div_bcd_out #(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        quo,
  input  logic [W-1:0]        rem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] quo_bcd,
  output logic [4*DIGITS-1:0] rem_bcd,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    qsr;
  logic [W-1:0]    rsr;
  logic [BW-1:0]   qacc;
  logic [BW-1:0]   racc;
  logic [BW-1:0]   qacc_adj;
  logic [BW-1:0]   racc_adj;
  logic [BW-1:0]   qacc_nxt;
  logic [BW-1:0]   racc_nxt;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    logic [3:0]    nib;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = a[4*i +: 4];
      r[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    return r;
  endfunction

  // Next accumulator values: adjust, then shift in the operand MSB.
  always_comb begin
    qacc_adj = add3(qacc);
    racc_adj = add3(racc);
    qacc_nxt = {qacc_adj[BW-2:0], qsr[W-1]};
    racc_nxt = {racc_adj[BW-2:0], rsr[W-1]};
  end

  // Control FSM plus datapath registers; the result registers load on the
  // last shift edge so they only ever hold complete conversions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      qsr     <= '0;
      rsr     <= '0;
      qacc    <= '0;
      racc    <= '0;
      quo_bcd <= '0;
      rem_bcd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qsr   <= quo;
            rsr   <= rem;
            qacc  <= '0;
            racc  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          qacc <= qacc_nxt;
          racc <= racc_nxt;
          qsr  <= {qsr[W-2:0], 1'b0};
          rsr  <= {rsr[W-2:0], 1'b0};
          if (cnt == LAST) begin
            quo_bcd <= qacc_nxt;
            rem_bcd <= racc_nxt;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign dbg_state = state;

endmodule
